// File: rtl/op_dispatch.sv
// op_dispatch: operation descriptor FIFO and frame-aligned dispatcher.
// Captures op descriptors strobed by csr_ope, buffers them in a DEPTH-entry
// FIFO and hands them one at a time to the update engine, each issue aligned
// to a frame_start pulse. Reports busy/queue/overflow status to the CSR block.
module op_dispatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [11:0] csr_opleft,
    input  logic [11:0] csr_opright,
    input  logic [11:0] csr_optop,
    input  logic [11:0] csr_opbottom,
    input  logic [7:0]  csr_opparam,
    input  logic [7:0]  csr_oplength,
    input  logic [7:0]  csr_opcmd,
    input  logic        csr_ope,

    input  logic        frame_start,

    output logic        op_valid,
    input  logic        op_ready,
    output logic [11:0] op_left,
    output logic [11:0] op_right,
    output logic [11:0] op_top,
    output logic [11:0] op_bottom,
    output logic [7:0]  op_param,
    output logic [7:0]  op_length,
    output logic [7:0]  op_cmd,
    input  logic        op_done,

    output logic        op_busy,
    output logic        op_queue,
    output logic        op_overflow
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ISSUE      = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    state_t        state;
    state_t        state_next;

    logic [71:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    logic [71:0]   wr_data;
    logic [71:0]   head;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          load_head;

    assign wr_data = {csr_opleft, csr_opright, csr_optop, csr_opbottom,
                      csr_opparam, csr_oplength, csr_opcmd};
    assign head    = mem[rd_ptr];
    assign full    = (count == FULL_COUNT);

    // A push into a full FIFO is still honoured when the head pops on the same edge.
    assign push    = csr_ope && (!full || pop);
    assign drop    = csr_ope && full && !pop;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; stray frame_start / op_done pulses fall through.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (op_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM output decode: head capture on frame, FIFO pop on engine accept.
    always_comb begin
        load_head = 1'b0;
        pop       = 1'b0;
        case (state)
            WAIT_FRAME: load_head = frame_start;
            ISSUE:      pop       = op_ready;
            default: begin
                load_head = 1'b0;
                pop       = 1'b0;
            end
        endcase
    end

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // FIFO storage; entries need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy count; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
        end
    end

    // Issued descriptor: latched from the FIFO head on frame, held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid  <= 1'b0;
            op_left   <= '0;
            op_right  <= '0;
            op_top    <= '0;
            op_bottom <= '0;
            op_param  <= '0;
            op_length <= '0;
            op_cmd    <= '0;
        end else begin
            if (load_head) begin
                op_valid <= 1'b1;
                {op_left, op_right, op_top, op_bottom,
                 op_param, op_length, op_cmd} <= head;
            end else if (pop) begin
                op_valid <= 1'b0;
            end
        end
    end

    // Status bits registered from post-edge state so they track the FSM/FIFO exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_busy     <= 1'b0;
            op_queue    <= 1'b0;
            op_overflow <= 1'b0;
        end else begin
            op_busy  <= (state_next != IDLE);
            op_queue <= (count_next != '0);
            if (drop) begin
                op_overflow <= 1'b1;
            end
        end
    end

endmodule
